// File: rtl/frame_update_scheduler_if.sv
// Request/acknowledge bundle between the frame update scheduler and the
// paddle/ball control blocks. Bit 0 = paddle 1, bit 1 = paddle 2, bit 2 = ball.
interface frame_update_scheduler_if;
    logic [2:0] o_Req;
    logic [2:0] i_Ack;

    // Scheduler side: issues requests, receives acknowledges.
    modport master (output o_Req, input i_Ack);
    // Object side: receives requests, returns acknowledges.
    modport slave  (input o_Req, output i_Ack);
endinterface

// File: rtl/frame_update_scheduler.sv
// Frame update scheduler: on the first vertical-blanking row it requests an
// update from paddle 1, paddle 2 and the ball in turn (one req/ack each, with
// a per-object ack timeout), then pulses frame-done and counts the frame.
module frame_update_scheduler #(
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                              clk,
    input  logic                              i_Reset,
    input  logic [9:0]                        i_Col_Count,
    input  logic [9:0]                        i_Row_Count,
    input  logic                              i_Enable,
    frame_update_scheduler_if.master          upd,
    output logic                              o_Frame_Done,
    output logic [7:0]                        o_Frame_Count,
    output logic [2:0]                        o_Timeout_Err,
    output logic                              o_Overrun
);

    localparam logic [9:0] TRIG_ROW   = 10'(ACTIVE_ROWS);
    localparam logic [9:0] LAST_COL_P = 10'(TOTAL_COLS);
    localparam logic [9:0] LAST_ROW_P = 10'(TOTAL_ROWS);
    localparam logic [7:0] TMO_LAST   = 8'(ACK_TIMEOUT - 1);
    // Timing parameters are consistent: blanking exists in both directions.
    localparam bit         PARAMS_OK  = (ACTIVE_COLS < TOTAL_COLS) && (ACTIVE_ROWS < TOTAL_ROWS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ_P1   = 3'd1,
        S_REQ_P2   = 3'd2,
        S_REQ_BALL = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t     state_q,     state_d;
    logic [7:0] tmo_cnt_q,   tmo_cnt_d;
    logic [2:0] req_q,       req_d;
    logic       done_q,      done_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [2:0] tmo_err_q,   tmo_err_d;
    logic       overrun_q,   overrun_d;

    logic       counts_ok_s;
    logic       trigger_s;
    logic [2:0] cur_bit_s;
    logic       ack_hit_s;
    logic       tmo_hit_s;
    state_t     adv_state_s;

    // Trigger detection and per-state request decode for the current cycle.
    always_comb begin
        counts_ok_s = PARAMS_OK && (i_Col_Count < LAST_COL_P) && (i_Row_Count < LAST_ROW_P);
        trigger_s   = counts_ok_s && (i_Row_Count == TRIG_ROW) && (i_Col_Count == 10'd0);
        cur_bit_s   = 3'b000;
        adv_state_s = S_IDLE;
        case (state_q)
            S_REQ_P1:   begin cur_bit_s = 3'b001; adv_state_s = S_REQ_P2;   end
            S_REQ_P2:   begin cur_bit_s = 3'b010; adv_state_s = S_REQ_BALL; end
            S_REQ_BALL: begin cur_bit_s = 3'b100; adv_state_s = S_DONE;     end
            default:    begin cur_bit_s = 3'b000; adv_state_s = S_IDLE;     end
        endcase
        // Only the ack bit of the object currently being requested counts.
        ack_hit_s = |(upd.i_Ack & cur_bit_s);
        tmo_hit_s = (tmo_cnt_q == TMO_LAST);
    end

    // Next-state, timeout, sticky-flag and registered-output computation.
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
        frame_cnt_d = frame_cnt_q;
        req_d       = 3'b000;
        done_d      = 1'b0;

        if (trigger_s && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = 8'd0;
                if (trigger_s && i_Enable) begin
                    state_d = S_REQ_P1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ_P1, S_REQ_P2, S_REQ_BALL: begin
                if (ack_hit_s) begin
                    // An ack on the timeout cycle wins: no error is recorded.
                    state_d   = adv_state_s;
                    tmo_cnt_d = 8'd0;
                end else if (tmo_hit_s) begin
                    state_d   = adv_state_s;
                    tmo_cnt_d = 8'd0;
                    tmo_err_d = tmo_err_q | cur_bit_s;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                tmo_cnt_d = 8'd0;
            end
            default: begin
                state_d   = S_IDLE;
                tmo_cnt_d = 8'd0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        case (state_d)
            S_REQ_P1:   req_d = 3'b001;
            S_REQ_P2:   req_d = 3'b010;
            S_REQ_BALL: req_d = 3'b100;
            default:    req_d = 3'b000;
        endcase

        if (state_d == S_DONE) begin
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            done_d      = 1'b0;
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            tmo_cnt_q   <= 8'd0;
            req_q       <= 3'b000;
            done_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
            tmo_err_q   <= 3'b000;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            req_q       <= req_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            tmo_err_q   <= tmo_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign upd.o_Req     = req_q;
    assign o_Frame_Done  = done_q;
    assign o_Frame_Count = frame_cnt_q;
    assign o_Timeout_Err = tmo_err_q;
    assign o_Overrun     = overrun_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Self-checking bench for frame_update_scheduler: a behavioural model tracks
// which object is being served and for how long, and a compare process checks
// every output on every falling edge. Directed scenarios add literal checks.
module tb_frame_update_scheduler;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] col;
    logic [9:0] row;
    logic       en;
    logic       done;
    logic [7:0] fcnt;
    logic [2:0] terr;
    logic       ovr;

    frame_update_scheduler_if u_if();

    frame_update_scheduler #(.ACK_TIMEOUT(T)) dut (
        .clk           (clk),
        .i_Reset       (rst),
        .i_Col_Count   (col),
        .i_Row_Count   (row),
        .i_Enable      (en),
        .upd           (u_if),
        .o_Frame_Done  (done),
        .o_Frame_Count (fcnt),
        .o_Timeout_Err (terr),
        .o_Overrun     (ovr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_obj: -1 = no schedule, 0..2 = object being served, 3 = frame finishing.
    int         m_obj;
    int         m_wait;
    logic [2:0] m_req;
    logic [2:0] m_err;
    logic       m_done;
    logic       m_ovr;
    logic [7:0] m_cnt;

    // Model advances on each clock edge using the inputs present before it.
    always @(posedge clk or posedge rst) begin : model
        int  nobj;
        int  nwait;
        bit  trig;
        if (rst) begin
            m_obj  <= -1;
            m_wait <= 0;
            m_req  <= 3'b000;
            m_err  <= 3'b000;
            m_done <= 1'b0;
            m_ovr  <= 1'b0;
            m_cnt  <= 8'd0;
        end else begin
            trig  = (row == 10'd480) && (col == 10'd0);
            nobj  = m_obj;
            nwait = m_wait;
            if (trig && m_obj != -1) m_ovr <= 1'b1;
            if (m_obj == -1) begin
                if (trig && en) begin nobj = 0; nwait = 0; end
            end else if (m_obj == 3) begin
                nobj = -1;
            end else if (u_if.i_Ack[m_obj]) begin
                nobj = m_obj + 1; nwait = 0;
            end else if (m_wait == T - 1) begin
                m_err[m_obj] <= 1'b1;
                nobj = m_obj + 1; nwait = 0;
            end else begin
                nwait = m_wait + 1;
            end
            m_obj  <= nobj;
            m_wait <= nwait;
            m_req  <= (nobj >= 0 && nobj <= 2) ? 3'(1 << nobj) : 3'b000;
            m_done <= (nobj == 3);
            if (nobj == 3) m_cnt <= m_cnt + 8'd1;
        end
    end

    bit cmp_en = 1'b0;

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("req",     32'(u_if.o_Req), 32'(m_req));
            chk("done",    32'(done),       32'(m_done));
            chk("count",   32'(fcnt),       32'(m_cnt));
            chk("tmo_err", 32'(terr),       32'(m_err));
            chk("overrun", 32'(ovr),        32'(m_ovr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_trig(input bit on);
        if (on) begin
            row = 10'd480; col = 10'd0;
        end else begin
            row = 10'd100; col = 10'd5;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req",   32'(u_if.o_Req), 32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_count", 32'(fcnt),       32'd0);
        chk("rst_err",   32'(terr),       32'd0);
        chk("rst_ovr",   32'(ovr),        32'd0);
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    // One scheduled frame; d = ack delay per object (>=1000 means never),
    // o = required request occupancy per object.
    task automatic run_frame(input int d0, d1, d2, input int o0, o1, o2);
        int d[3];
        int o[3];
        int occ;
        d = '{d0, d1, d2};
        o = '{o0, o1, o2};
        en = 1'b1;
        u_if.i_Ack = 3'b000;
        set_trig(1'b1);
        cycle();
        set_trig(1'b0);
        for (int k = 0; k < 3; k++) begin
            occ = 0;
            while (u_if.o_Req == 3'(1 << k) && occ < 300) begin
                u_if.i_Ack = (occ == d[k]) ? 3'(1 << k) : 3'b000;
                cycle();
                occ++;
            end
            u_if.i_Ack = 3'b000;
            chk($sformatf("occupancy_obj%0d", k), 32'(occ), 32'(o[k]));
        end
        chk("frame_done_pulse", 32'(done), 32'd1);
        cycle();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; u_if.i_Ack = 3'b000;
        set_trig(1'b0);
        cycle();
        cmp_en = 1'b1;
        do_reset();

        // Immediate acks: requests on +1..+3, done on +4, count 0 -> 1.
        en = 1'b1; u_if.i_Ack = 3'b111;
        set_trig(1'b1);
        cycle();
        set_trig(1'b0);
        chk("lat_req1", 32'(u_if.o_Req), 32'b001);
        cycle(); chk("lat_req2", 32'(u_if.o_Req), 32'b010);
        cycle(); chk("lat_req3", 32'(u_if.o_Req), 32'b100);
        cycle(); chk("lat_done", 32'(done), 32'd1);
        chk("lat_count", 32'(fcnt), 32'd1);
        cycle(); chk("lat_idle", 32'(u_if.o_Req), 32'b000);

        // Reset in the middle of the paddle-2 request.
        u_if.i_Ack = 3'b001;
        set_trig(1'b1);
        cycle();
        set_trig(1'b0);
        cycle();
        u_if.i_Ack = 3'b000;
        cycle();
        chk("mid_p2_req", 32'(u_if.o_Req), 32'b010);
        do_reset();
        u_if.i_Ack = 3'b111;
        set_trig(1'b1);
        cycle();
        set_trig(1'b0);
        chk("restart_p1", 32'(u_if.o_Req), 32'b001);
        cycle(); cycle(); cycle();
        chk("restart_done", 32'(done), 32'd1);
        u_if.i_Ack = 3'b000;
        cycle();

        // Delayed acks, ack exactly on the timeout cycle, and a missing ack.
        run_frame(5, 0, 14,   6, 1, 15);
        chk("no_tmo_a", 32'(terr), 32'b000);
        run_frame(3, 15, 2,   4, 16, 3);
        chk("ack_wins_tmo", 32'(terr), 32'b000);
        run_frame(0, 1000, 0, 1, 16, 1);
        chk("tmo_p2", 32'(terr), 32'b010);
        chk("count_4", 32'(fcnt), 32'd4);

        // Paused: the trigger is ignored, then re-enabling schedules again.
        en = 1'b0; u_if.i_Ack = 3'b111;
        set_trig(1'b1);
        cycle();
        set_trig(1'b0);
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("paused_req", 32'(u_if.o_Req), 32'b000);
            cycle();
        end
        chk("paused_count", 32'(fcnt), 32'd4);
        run_frame(0, 0, 0, 1, 1, 1);
        chk("count_5", 32'(fcnt), 32'd5);

        // 256 frames from reset wrap the frame counter back to 0.
        do_reset();
        en = 1'b1; u_if.i_Ack = 3'b111;
        for (int f = 0; f < 256; f++) begin
            set_trig(1'b1);
            cycle();
            set_trig(1'b0);
            repeat (4) cycle();
            if (f == 254) chk("count_255", 32'(fcnt), 32'd255);
        end
        chk("count_wrap", 32'(fcnt), 32'd0);

        // Second trigger during the ball request: overrun, sequence unaffected.
        u_if.i_Ack = 3'b011;
        set_trig(1'b1);
        cycle();
        set_trig(1'b0);
        cycle(); cycle();
        chk("ovr_ball_req", 32'(u_if.o_Req), 32'b100);
        u_if.i_Ack = 3'b000;
        set_trig(1'b1);
        cycle();
        set_trig(1'b0);
        chk("ovr_set", 32'(ovr), 32'd1);
        chk("ovr_still_ball", 32'(u_if.o_Req), 32'b100);
        u_if.i_Ack = 3'b100;
        cycle();
        chk("ovr_done", 32'(done), 32'd1);
        chk("ovr_count", 32'(fcnt), 32'd1);
        u_if.i_Ack = 3'b000;
        cycle();

        // Randomised traffic checked by the model.
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                set_trig(1'b1);
            end else begin
                row = 10'($urandom_range(0, 524));
                col = 10'($urandom_range(0, 799));
                if (row == 10'd480 && col == 10'd0) col = 10'd1;
            end
            u_if.i_Ack = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0)};
            if (i == 2000) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
